// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// pipelined_addsub_if : operand/result handshake bundle for pipelined_addsub.
// The sat lane exists only when ADDSUB_SATURATE_EN is defined.  Rev 1.0
// ============================================================================
interface pipelined_addsub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
`ifdef ADDSUB_SATURATE_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  sub,
      input  cin,
`ifdef ADDSUB_SATURATE_EN
      input  sat,
`endif
      input  out_ready,
      output in_ready,
      output out_valid,
      output sum,
      output cout,
      output ovf,
      output zero
   );

   modport master (
      output in_valid,
      output a,
      output b,
      output sub,
      output cin,
`ifdef ADDSUB_SATURATE_EN
      output sat,
`endif
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sum,
      input  cout,
      input  ovf,
      input  zero
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// pipelined_addsub : segment-pipelined adder/subtractor, one SEG slice per
// stage, valid/ready with global stall. Optional macro: ADDSUB_SATURATE_EN.
// Rev 1.0
// ============================================================================
module pipelined_addsub #(
   parameter int WIDTH = 64,
   parameter int SEG   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   pipelined_addsub_if.slave bus
);
   localparam int N = WIDTH / SEG;

   logic             stall;
   logic             accept;
   logic             last_valid;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Global stall: every stage freezes while the head result is refused.
   assign stall        = last_valid & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   assign accept       = bus.in_valid & ~stall;
   assign b_eff        = bus.sub ? ~bus.b : bus.b;
   assign c0           = bus.sub | bus.cin;

   for (genvar k = 0; k < N; k++) begin : g_stage
      logic                 valid_q;
      logic                 valid_d;
      logic [SEG-1:0]       a_seg;
      logic [SEG-1:0]       b_seg;
      logic                 c_in;
      logic [SEG:0]         seg_sum;
      logic [(k+1)*SEG-1:0] sum_d;
`ifdef ADDSUB_SATURATE_EN
      logic                 sat_in;
`endif

      if (k == 0) begin : g_src
         assign valid_d = accept;
         assign a_seg   = bus.a[SEG-1:0];
         assign b_seg   = b_eff[SEG-1:0];
         assign c_in    = c0;
         assign sum_d   = seg_sum[SEG-1:0];
`ifdef ADDSUB_SATURATE_EN
         assign sat_in  = bus.sat;
`endif
      end else begin : g_src
         assign valid_d = g_stage[k-1].valid_q;
         assign a_seg   = g_stage[k-1].g_skew.a_q[SEG-1:0];
         assign b_seg   = g_stage[k-1].g_skew.b_q[SEG-1:0];
         assign c_in    = g_stage[k-1].g_skew.carry_q;
         assign sum_d   = {seg_sum[SEG-1:0], g_stage[k-1].g_skew.sum_q};
`ifdef ADDSUB_SATURATE_EN
         assign sat_in  = g_stage[k-1].g_skew.sat_q;
`endif
      end

      assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            valid_q <= 1'b0;
         end else if (!stall) begin
            valid_q <= valid_d;
         end
      end

      if (k < N - 1) begin : g_skew
         // Skew registers keep only the slices that later stages still add.
         localparam int UW = WIDTH - (k + 1) * SEG;

         logic [UW-1:0]        a_q;
         logic [UW-1:0]        b_q;
         logic [UW-1:0]        a_d;
         logic [UW-1:0]        b_d;
         logic [(k+1)*SEG-1:0] sum_q;
         logic                 carry_q;
`ifdef ADDSUB_SATURATE_EN
         logic                 sat_q;
`endif

         if (k == 0) begin : g_up
            assign a_d = bus.a[WIDTH-1:SEG];
            assign b_d = b_eff[WIDTH-1:SEG];
         end else begin : g_up
            assign a_d = g_stage[k-1].g_skew.a_q[UW+SEG-1:SEG];
            assign b_d = g_stage[k-1].g_skew.b_q[UW+SEG-1:SEG];
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               a_q     <= '0;
               b_q     <= '0;
               sum_q   <= '0;
               carry_q <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
               sat_q   <= 1'b0;
`endif
            end else if (!stall) begin
               a_q     <= a_d;
               b_q     <= b_d;
               sum_q   <= sum_d;
               carry_q <= seg_sum[SEG];
`ifdef ADDSUB_SATURATE_EN
               sat_q   <= sat_in;
`endif
            end
         end
      end else begin : g_last
         logic [WIDTH-1:0] sum_q;
         logic [WIDTH-1:0] sum_fin;
         logic             cout_q;
         logic             ovf_q;
         logic             zero_q;
         logic             ovf_d;

         // Carry into the MSB is recovered from the MSB's own sum bit.
         assign ovf_d = (a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];

`ifdef ADDSUB_SATURATE_EN
         always_comb begin
            sum_fin = sum_d;
            if (sat_in && ovf_d) begin
               sum_fin = a_seg[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign sum_fin = sum_d;
`endif

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               sum_q  <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (!stall) begin
               sum_q  <= sum_fin;
               cout_q <= seg_sum[SEG];
               ovf_q  <= ovf_d;
               zero_q <= (sum_fin == '0);
            end
         end
      end
   end

   assign last_valid    = g_stage[N-1].valid_q;
   assign bus.out_valid = last_valid;
   assign bus.sum       = g_stage[N-1].g_last.sum_q;
   assign bus.cout      = g_stage[N-1].g_last.cout_q;
   assign bus.ovf       = g_stage[N-1].g_last.ovf_q;
   assign bus.zero      = g_stage[N-1].g_last.zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// tb_pipelined_addsub : directed bench for pipelined_addsub (64/16, 32/8 and
// single-stage 16/16 instances).  Rev 1.0
// ============================================================================
module tb_pipelined_addsub;
   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(64)) bus64 ();
   pipelined_addsub_if #(.WIDTH(32)) bus32 ();
   pipelined_addsub_if #(.WIDTH(16)) bus16 ();

   pipelined_addsub #(.WIDTH(64), .SEG(16)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64));
   pipelined_addsub #(.WIDTH(32), .SEG(8))  dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
   pipelined_addsub #(.WIDTH(16), .SEG(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

   task automatic idle_all();
      bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.sub = 1'b0; bus64.cin = 1'b0; bus64.out_ready = 1'b1;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.cin = 1'b0; bus32.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
`ifdef ADDSUB_SATURATE_EN
      bus64.sat = 1'b0; bus32.sat = 1'b0; bus16.sat = 1'b0;
`endif
   endtask

   // Presents one operation on the 64-bit DUT and waits (bounded) for its result.
   task automatic run_op64(input logic [63:0] a, input logic [63:0] b, input logic sub,
                           input logic cin, input logic sat,
                           output logic [63:0] sum, output logic [2:0] flags, output int lat);
      @(negedge clk);
      bus64.a = a; bus64.b = b; bus64.sub = sub; bus64.cin = cin;
`ifdef ADDSUB_SATURATE_EN
      bus64.sat = sat;
`else
      if (sat) bus64.cin = cin;
`endif
      bus64.in_valid = 1'b1;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      lat = 1;
      while (bus64.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (bus64.out_valid !== 1'b1) lat = -1;
      sum   = bus64.sum;
      flags = {bus64.cout, bus64.ovf, bus64.zero};
   endtask

   task automatic test_reset();
      idle_all();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      checks++;
      if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus64.out_valid); end
      checks++;
      if (bus64.sum !== 64'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0", bus64.sum); end
      checks++;
      if ({bus64.cout, bus64.ovf, bus64.zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus64.cout, bus64.ovf, bus64.zero}); end
      checks++;
      if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus64.in_ready); end
      checks++;
      if ({bus32.out_valid, bus16.out_valid} !== 2'b00) begin errors++; $display("FAIL reset_small_valid: got %b expected 00", {bus32.out_valid, bus16.out_valid}); end
   endtask

   task automatic test_carry_chain();
      logic [63:0] s; logic [2:0] f; int lat;
      run_op64(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, s, f, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL carry_latency: got %0d expected 4", lat); end
      checks++;
      if (s !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL carry_sum: got %h expected 0000000100000000", s); end
      checks++;
      if (f !== 3'b000) begin errors++; $display("FAIL carry_flags: got %b expected 000", f); end
      run_op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b0, s, f, lat);
      checks++;
      if (s !== 64'h0) begin errors++; $display("FAIL cin_sum: got %h expected 0", s); end
      checks++;
      if (f !== 3'b101) begin errors++; $display("FAIL cin_flags: got %b expected 101", f); end
   endtask

   task automatic test_sub();
      logic [63:0] s; logic [2:0] f; int lat;
      run_op64(64'd5, 64'd5, 1'b1, 1'b1, 1'b0, s, f, lat);
      checks++;
      if (s !== 64'h0) begin errors++; $display("FAIL sub_eq_sum: got %h expected 0", s); end
      checks++;
      if (f !== 3'b101) begin errors++; $display("FAIL sub_eq_flags: got %b expected 101", f); end
      run_op64(64'd0, 64'd1, 1'b1, 1'b0, 1'b0, s, f, lat);
      checks++;
      if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_borrow_sum: got %h expected ffffffffffffffff", s); end
      checks++;
      if (f !== 3'b000) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 000", f); end
      run_op64(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b0, s, f, lat);
      checks++;
      if (s !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_ovf_sum: got %h expected 7fffffffffffffff", s); end
      checks++;
      if (f !== 3'b110) begin errors++; $display("FAIL sub_ovf_flags: got %b expected 110", f); end
   endtask

   task automatic test_overflow();
      logic [63:0] s; logic [2:0] f; int lat;
      run_op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, s, f, lat);
      checks++;
      if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum: got %h expected 8000000000000000", s); end
      checks++;
      if (f !== 3'b010) begin errors++; $display("FAIL ovf_flags: got %b expected 010", f); end
`ifdef ADDSUB_SATURATE_EN
      run_op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, s, f, lat);
      checks++;
      if (s !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sat_pos_sum: got %h expected 7fffffffffffffff", s); end
      checks++;
      if (f !== 3'b010) begin errors++; $display("FAIL sat_pos_flags: got %b expected 010", f); end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL sat_latency: got %0d expected 4", lat); end
      run_op64(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b1, s, f, lat);
      checks++;
      if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL sat_neg_sum: got %h expected 8000000000000000", s); end
      checks++;
      if (f !== 3'b110) begin errors++; $display("FAIL sat_neg_flags: got %b expected 110", f); end
      run_op64(64'd5, 64'd5, 1'b1, 1'b0, 1'b1, s, f, lat);
      checks++;
      if ({s == 64'h0, f} !== 4'b1101) begin errors++; $display("FAIL sat_noovf: got sum %h flags %b expected 0 / 101", s, f); end
`endif
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int seen  = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (bus64.out_valid !== ((c >= 4 && c < 12) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL b2b_valid: cycle %0d got %b", c, bus64.out_valid);
         end
         if (bus64.out_valid === 1'b1) begin
            if (first < 0) first = c;
            checks++;
            if (bus64.sum !== 64'h0001_0000_0000_0000 + 64'(seen)) begin
               errors++; $display("FAIL b2b_sum: got %h expected %h", bus64.sum, 64'h0001_0000_0000_0000 + 64'(seen));
            end
            seen++;
         end
         if (c < 8) begin
            bus64.a = 64'h0000_FFFF_FFFF_FFFF; bus64.b = 64'(c + 1);
            bus64.sub = 1'b0; bus64.cin = 1'b0; bus64.in_valid = 1'b1;
         end else begin
            bus64.in_valid = 1'b0;
         end
      end
      checks++;
      if (first !== 4) begin errors++; $display("FAIL b2b_first: got %0d expected 4", first); end
      checks++;
      if (seen !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", seen); end
   endtask

   task automatic test_stall();
      int          next_op = 0;
      int          got = 0;
      bit          held_valid = 1'b0;
      logic [63:0] held = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         bus64.out_ready = !(c >= 6 && c < 12);
         #1;
         if (bus64.out_valid === 1'b1 && bus64.out_ready === 1'b0) begin
            checks++;
            if (bus64.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, bus64.in_ready); end
            if (held_valid) begin
               checks++;
               if (bus64.sum !== held) begin errors++; $display("FAIL stall_hold: got %h expected %h", bus64.sum, held); end
            end
            held = bus64.sum;
            held_valid = 1'b1;
         end else begin
            held_valid = 1'b0;
         end
         if (bus64.out_valid === 1'b1 && bus64.out_ready === 1'b1) begin
            checks++;
            if (bus64.sum !== 64'h1000 + 64'(got)) begin errors++; $display("FAIL stall_order: got %h expected %h", bus64.sum, 64'h1000 + 64'(got)); end
            got++;
         end
         if (next_op < 8) begin
            bus64.a = 64'h1000; bus64.b = 64'(next_op); bus64.sub = 1'b0; bus64.cin = 1'b0;
            bus64.in_valid = 1'b1;
            if (bus64.in_ready === 1'b1) next_op++;
         end else begin
            bus64.in_valid = 1'b0;
         end
      end
      bus64.out_ready = 1'b1;
      checks++;
      if (got !== 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", got); end
   endtask

   task automatic test_reset_inflight();
      int stale = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus64.a = 64'hFFFF_FFFF_FFFF_FFFF; bus64.b = 64'hFFFF_FFFF_FFFF_FFFF;
         bus64.sub = 1'b0; bus64.cin = 1'b0; bus64.in_valid = 1'b1;
      end
      @(negedge clk);
      bus64.in_valid = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++;
      if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus64.out_valid); end
      checks++;
      if ({bus64.sum, bus64.cout, bus64.ovf, bus64.zero} !== 67'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got sum %h flags %b expected 0", bus64.sum, {bus64.cout, bus64.ovf, bus64.zero});
      end
      checks++;
      if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus64.in_ready); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus64.out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d stale results expected 0", stale); end
   endtask

   task automatic test_narrow();
      int lat = 1;
      @(negedge clk);
      bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h1; bus32.sub = 1'b0; bus32.cin = 1'b0; bus32.in_valid = 1'b1;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      while (bus32.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL n32_latency: got %0d expected 4", lat); end
      checks++;
      if (bus32.sum !== 32'h0) begin errors++; $display("FAIL n32_sum: got %h expected 0", bus32.sum); end
      checks++;
      if ({bus32.cout, bus32.ovf, bus32.zero} !== 3'b101) begin errors++; $display("FAIL n32_flags: got %b expected 101", {bus32.cout, bus32.ovf, bus32.zero}); end
   endtask

   task automatic test_single_stage();
      int lat = 1;
      @(negedge clk);
      bus16.a = 16'h7FFF; bus16.b = 16'h1; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      while (bus16.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL n16_latency: got %0d expected 1", lat); end
      checks++;
      if (bus16.sum !== 16'h8000) begin errors++; $display("FAIL n16_sum: got %h expected 8000", bus16.sum); end
      checks++;
      if ({bus16.cout, bus16.ovf, bus16.zero} !== 3'b010) begin errors++; $display("FAIL n16_flags: got %b expected 010", {bus16.cout, bus16.ovf, bus16.zero}); end
   endtask

   initial begin
      test_reset();
      test_carry_chain();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
      test_narrow();
      test_single_stage();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
